// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the emulated SPI ADC responder.
package adc_spi_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Configuration word bit positions
   localparam int CFG_SD_BIT  = 5;
   localparam int CFG_OS_BIT  = 4;
   localparam int CFG_S1_BIT  = 3;
   localparam int CFG_S0_BIT  = 2;
   localparam int CFG_UNI_BIT = 1;
   localparam int CFG_SLP_BIT = 0;

   // Single-ended, channel 0, unipolar, awake
   localparam logic [5:0] CFG_RESET = 6'b100010;

   localparam int N_CHANNELS = 8;

   function automatic logic [2:0] cfg_channel(input logic [5:0] cfg);
      return {cfg[CFG_OS_BIT], cfg[CFG_S1_BIT], cfg[CFG_S0_BIT]};
   endfunction

endpackage

// File: rtl/adc_spi_responder_spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus edge detect
// against one extra registered copy of the synchronized value.
module spi_in_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // Synchronizer chain and previous-value register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave that emulates an 8-channel ADC: returns a channel sample per
// frame, selected by the configuration word received in the previous frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame; adc_dout held 0, waiting for cs_n falling edge
// ST_SHIFT | frame active; din sampled on sclk rise, dout shifted on fall
// ST_DONE  | all result bits sent; sclk ignored, dout 0 until cs_n rises
module adc_spi_responder
   import adc_spi_responder_pkg::*;
#(
   parameter int DATA_BITS   = 12,
   parameter int CFG_BITS    = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      adc_sclk,
   input  logic                      adc_cs_n,
   input  logic                      adc_din,
   output logic                      adc_dout,
   input  logic [8*DATA_BITS-1:0]    ch_value,
   output logic [CFG_BITS-1:0]       cfg_word,
   output logic                      cfg_valid,
   output logic                      short_frame,
   output logic [15:0]               frame_count
);

   // Down-counter of result bits still to be clocked out in this frame
   localparam int                BL_W      = $clog2(DATA_BITS + 1);
   localparam logic [BL_W-1:0]   BL_LOAD   = BL_W'(DATA_BITS);
   localparam logic [BL_W-1:0]   BL_CFG_TC = BL_W'(DATA_BITS - CFG_BITS + 1);
   localparam logic [BL_W-1:0]   BL_ONE    = BL_W'(1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_BITS-1:0]  r_res_sr;
   logic [CFG_BITS-1:0]   r_cfg_sr;
   logic [CFG_BITS-1:0]   r_cfg_word;
   logic [CFG_BITS-1:0]   r_pending;
   logic [BL_W-1:0]       r_bits_left;
   logic                  r_cfg_done;
   logic                  r_cfg_valid;
   logic                  r_short;
   logic [15:0]           r_frame_cnt;

   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_cs_q, w_cs_rise, w_cs_fall;
   logic w_din_q, w_din_rise, w_din_fall;
   logic w_start, w_end, w_rise_ok, w_fall_ok, w_frame_ok;
   logic [2:0]            w_ch_idx;
   logic [DATA_BITS-1:0]  w_sample;
   logic [DATA_BITS-1:0]  w_result;
   logic [CFG_BITS-1:0]   w_cfg_next;
   logic                  w_unused;

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .i_d(adc_sclk),
      .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .reset_n(reset_n), .i_d(adc_cs_n),
      .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk), .reset_n(reset_n), .i_d(adc_din),
      .o_q(w_din_q), .o_rise(w_din_rise), .o_fall(w_din_fall)
   );

   assign w_unused = &{1'b0, w_sclk_q, w_cs_q, w_din_rise, w_din_fall,
                       r_pending[CFG_SD_BIT]};

   // A cs_n rise takes priority over any sclk edge seen in the same clk
   assign w_start    = (r_state == ST_IDLE) & w_cs_fall;
   assign w_end      = (r_state != ST_IDLE) & w_cs_rise;
   assign w_rise_ok  = (r_state == ST_SHIFT) & w_sclk_rise & ~w_cs_rise;
   assign w_fall_ok  = (r_state == ST_SHIFT) & w_sclk_fall & ~w_cs_rise;
   assign w_frame_ok = w_end & r_cfg_done;
   assign w_cfg_next = {r_cfg_sr[CFG_BITS-2:0], w_din_q};
   assign w_ch_idx   = cfg_channel(r_pending[5:0]);

   // Result word from the pending configuration and the live channel inputs
   always_comb begin
      w_sample = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (w_ch_idx == 3'(i)) begin
            w_sample = ch_value[i*DATA_BITS +: DATA_BITS];
         end
      end
      w_result = w_sample;
      if (!r_pending[CFG_UNI_BIT]) begin
         w_result[DATA_BITS-1] = ~w_sample[DATA_BITS-1];
      end
      if (r_pending[CFG_SLP_BIT]) begin
         w_result = '0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_rise && (r_bits_left == BL_ONE)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_cs_rise) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift registers, configuration capture, pulses and frame counter.
   // The counter is written every cycle so it always reloads from itself.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_res_sr    <= '0;
         r_cfg_sr    <= '0;
         r_cfg_word  <= CFG_BITS'(CFG_RESET);
         r_pending   <= CFG_BITS'(CFG_RESET);
         r_bits_left <= '0;
         r_cfg_done  <= 1'b0;
         r_cfg_valid <= 1'b0;
         r_short     <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_cfg_valid <= 1'b0;
         r_short     <= 1'b0;
         r_frame_cnt <= r_frame_cnt + {15'd0, w_frame_ok};
         if (w_start) begin
            r_res_sr    <= w_result;
            r_cfg_sr    <= '0;
            r_bits_left <= BL_LOAD;
            r_cfg_done  <= 1'b0;
         end else if (w_end) begin
            r_short <= ~r_cfg_done;
         end else if (w_rise_ok) begin
            r_cfg_sr    <= w_cfg_next;
            r_bits_left <= r_bits_left - BL_ONE;
            if (r_bits_left == BL_CFG_TC) begin
               r_cfg_word  <= w_cfg_next;
               r_pending   <= w_cfg_next;
               r_cfg_valid <= 1'b1;
               r_cfg_done  <= 1'b1;
            end
         end else if (w_fall_ok) begin
            r_res_sr <= {r_res_sr[DATA_BITS-2:0], 1'b0};
         end
      end
   end

   assign adc_dout    = (r_state == ST_SHIFT) & r_res_sr[DATA_BITS-1];
   assign cfg_word    = r_cfg_word;
   assign cfg_valid   = r_cfg_valid;
   assign short_frame = r_short;
   assign frame_count = r_frame_cnt;

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, conversion result width in bits.
REQ-002 SHALL have parameter CFG_BITS, default 6, configuration word width in bits.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on adc_sclk, adc_cs_n and adc_din.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rises on clk.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port adc_sclk, input, 1, SPI clock from the master.
REQ-007 SHALL have port adc_cs_n, input, 1, frame select from the master, active low.
REQ-008 SHALL have port adc_din, input, 1, configuration bits from the master.
REQ-009 SHALL have port adc_dout, output, 1, result bits to the master.
REQ-010 SHALL have port ch_value, input, 8*DATA_BITS, emulated channel samples; channel n occupies bits [n*DATA_BITS +: DATA_BITS].
REQ-011 SHALL have port cfg_word, output, CFG_BITS, last accepted configuration word.
REQ-012 SHALL have port cfg_valid, output, 1, one-clk pulse when a configuration word is accepted.
REQ-013 SHALL have port short_frame, output, 1, one-clk pulse when a frame ends with fewer than CFG_BITS sclk rising edges.
REQ-014 SHALL have port frame_count, output, 16, count of completed frames; wraps 0xFFFF->0.

Function
REQ-015 SHALL pass adc_sclk, adc_cs_n and adc_din through SYNC_STAGES flops, then detect edges against one extra registered copy.
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 IDLE->SHIFT on a synchronized cs_n falling edge; SHIFT->DONE after DATA_BITS sclk rising edges; SHIFT or DONE->IDLE on a cs_n rising edge.
REQ-018 On the cs_n falling edge, SHALL load the result shift register from the pending configuration and a ch_value snapshot, and drive the result MSB on adc_dout within SYNC_STAGES+1 clk.
REQ-019 SHALL sample adc_din on each sclk rising edge in SHIFT, MSB first, into the config shift register, and shift adc_dout to the next bit on each sclk falling edge.
REQ-020 At the CFG_BITS-th rising edge, SHALL latch cfg_word, pulse cfg_valid, and make the word the pending configuration for the next frame (one-frame pipeline).
REQ-021 Config decode: bit5 S/D (reported only), bit4 O/S, bit3 S1, bit2 S0, bit1 UNI, bit0 SLP; channel index = {O/S,S1,S0}.
REQ-022 Result = ch_value[index]; if UNI=0, MSB inverted (offset binary to two's complement); if SLP=1, result = 0.
REQ-023 In DONE, SHALL ignore further sclk edges and hold adc_dout at 0.
REQ-024 On a cs_n rise with fewer than CFG_BITS edges, SHALL pulse short_frame, keep the previous pending configuration, and not increment frame_count.
REQ-025 On a cs_n rise with CFG_BITS edges or more, SHALL increment frame_count by 1.
REQ-026 adc_dout SHALL be 0 whenever state is IDLE.
REQ-027 If an sclk edge and a cs_n rise are detected in the same clk, the cs_n rise wins and the edge is discarded.
REQ-028 SHALL operate correctly when each sclk half-period lasts at least SYNC_STAGES+2 clk cycles.

Reset
REQ-029 While reset_n=0 at a clk edge, SHALL set state IDLE, adc_dout=0, cfg_word=6'b100010, pending configuration=6'b100010, cfg_valid=0, short_frame=0, frame_count=0, and clear synchronizers and shift registers.
REQ-030 Reset mid-frame SHALL abort the frame without cfg_valid or short_frame; the first frame after reset SHALL require a fresh cs_n falling edge.

Structure
REQ-031 Shared package SHALL hold the state enum, the config bit-position constants and the reset config constant 6'b100010.
REQ-032 One sub-module, spi_in_sync (SYNC_STAGES synchronizer plus rise/fall detect), SHALL be instantiated once per input.

Verification
REQ-033 After reset, ch0=0xABC, one 12-bit frame with din=6'b100010 -> dout bits 0xABC MSB first, cfg_valid pulse, cfg_word=0x22, frame_count=1.
REQ-034 Frame 1 din=6'b111010 (channel 6), ch6=0x123 -> frame 1 returns ch0 and frame 2 returns 0x123 (pipeline).
REQ-035 UNI=0 configuration, then ch value 0x800 -> next frame returns 0x000; SLP=1 -> next frame returns 0x000 whatever ch_value is.
REQ-036 cs_n raised after 4 sclk edges -> short_frame pulse, cfg_word unchanged, frame_count unchanged.
REQ-037 16 sclk edges in one frame -> bits 13-16 read 0, frame_count+1; reset_n low at edge 7 -> state IDLE, dout=0, no pulses.
REQ-038 65536 valid frames -> frame_count wraps to 0.
